// File: rtl/cell_cache_select.sv
// rtl/cell_cache_select.sv - tape-cell cache select stage with lock, fill and dirty write-back
module cell_cache_select #(
    parameter int NENTRIES = 4,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   ins,
    input  logic [AW-1:0] ptr,
    input  logic          branch_en,
    output logic [15:0]   out_ins,
    output logic          stall,
    output logic [DW-1:0] val,
    output logic          val_valid,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);
    localparam int IW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
    localparam logic [3:0] OP_PLUS  = 4'h1;
    localparam logic [3:0] OP_MINUS = 4'h2;
    localparam logic [3:0] OP_BRZ   = 4'h5;

    typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [NENTRIES-1:0]   valid_q, locked_q, dirty_q;
    logic [AW-1:0]         tag_q  [NENTRIES];
    logic [DW-1:0]         data_q [NENTRIES];
    logic [IW-1:0]         rr_q;
    logic [AW-1:0]         miss_addr_q;
    logic [IW-1:0]         victim_q;
    logic                  victim_rr_q;
    logic                  branch_q;

    logic                  cell_op, lock_op, squashed, wb_same;
    logic                  hit, hit_ok, complete, start_miss, fill_now;
    logic [IW-1:0]         hit_idx;
    logic                  inv_found, rr_found, victim_ok;
    logic [IW-1:0]         inv_idx, rr_idx, victim_idx;
    logic [NENTRIES-1:0]   wb_match;

    // Round-robin scan position: base + k wrapped into the entry range.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NENTRIES) s = s - NENTRIES;
        return IW'(s);
    endfunction

    assign out_ins  = ins;
    assign cell_op  = (ins[15:12] == OP_PLUS) || (ins[15:12] == OP_MINUS) || (ins[15:12] == OP_BRZ);
    assign lock_op  = (ins[15:12] == OP_PLUS) || (ins[15:12] == OP_MINUS);
    assign squashed = branch_en || branch_q;
    assign wb_same  = wb_en && (wb_addr == ptr);
    assign fill_now = (state_q == S_WAIT) && mem_rsp_valid;
    assign complete = fill_now && !squashed && cell_op && (ptr == miss_addr_q);
    assign hit_ok   = !squashed && cell_op && hit && !locked_q[hit_idx] && !wb_same;
    assign victim_ok  = inv_found || rr_found;
    assign victim_idx = inv_found ? inv_idx : rr_idx;
    assign start_miss = (state_q == S_IDLE) && !squashed && cell_op && !hit && victim_ok;

    // Tag lookup against registered entry state, plus writeback tag match on locked entries.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        wb_match = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == ptr)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            wb_match[i] = wb_en && valid_q[i] && locked_q[i] && (tag_q[i] == wb_addr);
        end
    end

    // Victim choice: lowest invalid entry, else first unlocked entry at or after rr.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        rr_found  = 1'b0;
        rr_idx    = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (!inv_found && !valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = IW'(i);
            end
        end
        for (int k = 0; k < NENTRIES; k++) begin
            if (!rr_found && !locked_q[wrap_add(rr_q, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_add(rr_q, k);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_miss) state_d = dirty_q[victim_idx] ? S_EVICT : S_FILL;
            S_EVICT: if (mem_req_ready) state_d = S_FILL;
            S_FILL:  if (mem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (mem_rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage outputs: response completion takes priority, then hit, else the op stalls.
    always_comb begin
        stall     = 1'b0;
        val_valid = 1'b0;
        val       = '0;
        if (!squashed && cell_op) begin
            if (complete) begin
                val_valid = 1'b1;
                val       = mem_rsp_data;
            end else if (hit_ok) begin
                val_valid = 1'b1;
                val       = data_q[hit_idx];
            end else begin
                stall = 1'b1;
            end
        end
    end

    // Entry flags, miss bookkeeping and the registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            locked_q      <= '0;
            dirty_q       <= '0;
            rr_q          <= '0;
            miss_addr_q   <= '0;
            victim_q      <= '0;
            victim_rr_q   <= 1'b0;
            branch_q      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            branch_q <= branch_en;
            for (int i = 0; i < NENTRIES; i++) begin
                if (wb_match[i]) begin
                    locked_q[i] <= 1'b0;
                    dirty_q[i]  <= 1'b1;
                end
            end
            if (hit_ok && lock_op) locked_q[hit_idx] <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_miss) begin
                        miss_addr_q          <= ptr;
                        victim_q             <= victim_idx;
                        victim_rr_q          <= !inv_found;
                        valid_q[victim_idx]  <= 1'b0;
                        locked_q[victim_idx] <= 1'b0;
                        dirty_q[victim_idx]  <= 1'b0;
                        mem_req_valid        <= 1'b1;
                        if (dirty_q[victim_idx]) begin
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= tag_q[victim_idx];
                            mem_req_wdata <= data_q[victim_idx];
                        end else begin
                            mem_req_we   <= 1'b0;
                            mem_req_addr <= ptr;
                        end
                    end
                end
                S_EVICT: begin
                    if (mem_req_ready) begin
                        mem_req_we   <= 1'b0;
                        mem_req_addr <= miss_addr_q;
                    end
                end
                S_FILL: begin
                    if (mem_req_ready) mem_req_valid <= 1'b0;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        valid_q[victim_q]  <= 1'b1;
                        dirty_q[victim_q]  <= 1'b0;
                        locked_q[victim_q] <= complete && lock_op;
                        if (victim_rr_q)
                            rr_q <= (victim_q == IW'(NENTRIES - 1)) ? '0 : victim_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry tag/data storage; qualified by the flags, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NENTRIES; i++) begin
            if (wb_match[i]) data_q[i] <= wb_data;
        end
        if (fill_now) begin
            tag_q[victim_q]  <= miss_addr_q;
            data_q[victim_q] <= mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_cell_cache_select.sv
// tb/tb_cell_cache_select.sv - scoreboard bench for cell_cache_select
module tb_cell_cache_select;
    localparam logic [15:0] OP_PLUS = 16'h1000;
    localparam logic [15:0] OP_BRZ  = 16'h5000;
    localparam logic [15:0] OP_NOP  = 16'h3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ins = '0, ptr = '0;
    logic        branch_en = 1'b0;
    logic [15:0] out_ins;
    logic        stall, val_valid;
    logic [15:0] val;
    logic        mem_req_valid, mem_req_we;
    logic        mem_req_ready = 1'b1;
    logic [15:0] mem_req_addr, mem_req_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [15:0] mem_rsp_data = '0;
    logic        wb_en = 1'b0;
    logic [15:0] wb_addr = '0, wb_data = '0;

    int total = 0;
    int bad = 0;
    logic [15:0] sb [$];
    logic [15:0] mem [logic [15:0]];
    logic [15:0] cell_ref [logic [15:0]];
    int          rd_cnt = 0, wr_cnt = 0;
    logic [15:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        s_stall, s_vv, s_rv, s_we;
    logic [15:0] s_val, s_addr, s_wdata;
    int          lat, r0, w0;

    always #5 clk = ~clk;

    cell_cache_select #(.NENTRIES(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .ptr(ptr), .branch_en(branch_en),
        .out_ins(out_ins), .stall(stall), .val(val), .val_valid(val_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_get(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'h5a00;
    endfunction

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        if (cell_ref.exists(a)) return cell_ref[a];
        return mem_get(a);
    endfunction

    // One clock: sample at negedge, score completions, model memory, then drive the response.
    task automatic cycle();
        logic        fire;
        logic [15:0] faddr;
        logic [15:0] e;
        fire = 1'b0;
        faddr = '0;
        @(negedge clk);
        s_stall = stall; s_vv = val_valid; s_val = val;
        s_rv = mem_req_valid; s_we = mem_req_we; s_addr = mem_req_addr; s_wdata = mem_req_wdata;
        if (val_valid) begin
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else begin
                e = sb.pop_front();
                chk("val", val, e);
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_we) begin
                mem[mem_req_addr] = mem_req_wdata;
                wr_cnt++; wr_addr = mem_req_addr; wr_data = mem_req_wdata;
            end else begin
                rd_cnt++; rd_addr = mem_req_addr;
                fire = 1'b1; faddr = mem_req_addr;
            end
        end
        @(posedge clk);
        #1;
        mem_rsp_valid = fire;
        mem_rsp_data  = fire ? mem_get(faddr) : 16'h0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (!s_stall) begin
                l = n;
                break;
            end
        end
        chk("op_done", l >= 0, 1);
        chk("op_vv", s_vv, 1);
        ins = OP_NOP;
    endtask

    task automatic do_op(input logic [15:0] op, input logic [15:0] a, output int l);
        ins = op; ptr = a;
        sb.push_back(ref_get(a));
        wait_done(l);
    endtask

    task automatic do_wb(input logic [15:0] a, input logic [15:0] d);
        ins = OP_NOP;
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cell_ref[a] = d;
        cycle();
        wb_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ins = '0; ptr = '0; branch_en = 1'b0; wb_en = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cell_ref.delete();
        sb.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem[16'h0010] = 16'h0007;
        do_reset();

        // reset state, non-cell op never stalls
        ins = OP_NOP; ptr = 16'h0099;
        cycle();
        chk("rst_stall", s_stall, 0);
        chk("rst_vv", s_vv, 0);
        chk("rst_val", s_val, 0);
        chk("rst_req_valid", s_rv, 0);
        chk("rst_req_we", s_we, 0);
        chk("rst_req_addr", s_addr, 0);
        chk("rst_req_wdata", s_wdata, 0);
        chk("out_ins", out_ins, 16'h3000);

        // cold miss
        ins = OP_PLUS; ptr = 16'h0010; sb.push_back(ref_get(16'h0010));
        cycle();
        chk("cm_stall0", s_stall, 1);
        chk("cm_req0", s_rv, 0);
        cycle();
        chk("cm_req1", s_rv, 1);
        chk("cm_we1", s_we, 0);
        chk("cm_addr1", s_addr, 16'h0010);
        cycle();
        chk("cm_stall2", s_stall, 0);
        chk("cm_vv2", s_vv, 1);
        chk("cm_val2", s_val, 16'h0007);

        // locked cell stalls until writeback, hits the cycle after
        sb.push_back(16'h0008);
        repeat (3) begin
            cycle();
            chk("lk_stall", s_stall, 1);
        end
        wb_en = 1'b1; wb_addr = 16'h0010; wb_data = 16'h0008; cell_ref[16'h0010] = 16'h0008;
        cycle();
        chk("wb_same_stall", s_stall, 1);
        wb_en = 1'b0;
        cycle();
        chk("lk_hit_stall", s_stall, 0);
        chk("lk_hit_vv", s_vv, 1);
        chk("lk_hit_val", s_val, 16'h0008);
        do_wb(16'h0010, 16'h0008);

        // BRZ hit on an unlocked zero cell
        do_op(OP_PLUS, 16'h0020, lat);
        chk("fill_lat", lat, 2);
        do_wb(16'h0020, 16'h0000);
        r0 = rd_cnt; w0 = wr_cnt;
        ins = OP_BRZ; ptr = 16'h0020;
        repeat (3) begin
            sb.push_back(16'h0000);
            cycle();
            chk("brz_vv", s_vv, 1);
            chk("brz_stall", s_stall, 0);
        end
        chk("brz_rd", rd_cnt, r0);
        chk("brz_wr", wr_cnt, w0);
        do_op(OP_PLUS, 16'h0020, lat);
        chk("brz_unlocked", lat, 0);
        do_wb(16'h0020, 16'h0000);

        // dirty eviction of rr entry
        do_reset();
        for (int a = 1; a <= 4; a++) do_op(OP_PLUS, 16'(a), lat);
        do_wb(16'h0001, 16'h0055);
        r0 = rd_cnt; w0 = wr_cnt;
        do_op(OP_PLUS, 16'h0005, lat);
        chk("ev_lat", lat, 3);
        chk("ev_wr_cnt", wr_cnt, w0 + 1);
        chk("ev_wr_addr", wr_addr, 16'h0001);
        chk("ev_wr_data", wr_data, 16'h0055);
        chk("ev_rd_cnt", rd_cnt, r0 + 1);
        chk("ev_rd_addr", rd_addr, 16'h0005);
        for (int a = 2; a <= 5; a++) do_wb(16'(a), ref_get(16'(a)));
        do_op(OP_BRZ, 16'h0002, lat);
        chk("ev_keep2", lat, 0);
        do_op(OP_BRZ, 16'h0001, lat);
        chk("ev_refetch_lat", lat, 3);
        chk("rr_adv_wr", wr_addr, 16'h0002);

        // backpressure during FILL
        do_reset();
        mem_req_ready = 1'b0;
        r0 = rd_cnt;
        ins = OP_PLUS; ptr = 16'h0030; sb.push_back(ref_get(16'h0030));
        cycle();
        chk("bp_stall0", s_stall, 1);
        repeat (5) begin
            cycle();
            chk("bp_valid", s_rv, 1);
            chk("bp_addr", s_addr, 16'h0030);
            chk("bp_we", s_we, 0);
            chk("bp_stall", s_stall, 1);
        end
        mem_req_ready = 1'b1;
        wait_done(lat);
        chk("bp_lat", lat, 1);
        chk("bp_accepts", rd_cnt, r0 + 1);

        // squash on a miss
        do_reset();
        r0 = rd_cnt;
        ins = OP_PLUS; ptr = 16'h0040; branch_en = 1'b1;
        cycle();
        chk("sq_stall0", s_stall, 0);
        chk("sq_vv0", s_vv, 0);
        branch_en = 1'b0;
        cycle();
        chk("sq_stall1", s_stall, 0);
        chk("sq_vv1", s_vv, 0);
        ins = OP_NOP;
        cycle();
        chk("sq_noreq", s_rv, 0);
        chk("sq_rd", rd_cnt, r0);

        // all entries locked
        do_reset();
        for (int a = 1; a <= 4; a++) do_op(OP_PLUS, 16'(a), lat);
        r0 = rd_cnt;
        ins = OP_PLUS; ptr = 16'h0006; sb.push_back(ref_get(16'h0006));
        repeat (3) begin
            cycle();
            chk("al_stall", s_stall, 1);
            chk("al_noreq", s_rv, 0);
        end
        chk("al_rd", rd_cnt, r0);
        wb_en = 1'b1; wb_addr = 16'h0003; wb_data = 16'h0033; cell_ref[16'h0003] = 16'h0033;
        cycle();
        chk("al_wb_stall", s_stall, 1);
        wb_en = 1'b0;
        wait_done(lat);
        chk("al_lat", lat, 3);
        chk("al_wr_addr", wr_addr, 16'h0003);
        chk("al_wr_data", wr_data, 16'h0033);
        chk("al_rd_addr", rd_addr, 16'h0006);

        // reset mid-miss, stale response ignored
        do_reset();
        ins = OP_PLUS; ptr = 16'h0070;
        cycle();
        cycle();
        do_reset();
        ins = OP_BRZ; ptr = 16'h0070;
        sb.push_back(ref_get(16'h0070));
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'hbeef;
        cycle();
        chk("rm_stall", s_stall, 1);
        chk("rm_vv", s_vv, 0);
        wait_done(lat);
        chk("rm_lat", lat, 1);

        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
